// File: rtl/bullet_motion.sv
// bullet_motion: owns one bullet's position and velocity, advances it once per frame tick and reflects it off walls.
// Defining BULLET_COOLDOWN_EN adds a relaunch cooldown of COOLDOWN_FRAMES ticks after each retirement.
module bullet_motion #(
    parameter int LIFETIME_FRAMES = 300,
    parameter int MAX_BOUNCES     = 5,
    parameter int BULLET_SIZE     = 2
`ifdef BULLET_COOLDOWN_EN
    , parameter int COOLDOWN_FRAMES = 30
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] tankX,
    input  logic [9:0] tankY,
    input  logic [3:0] dirX,
    input  logic [3:0] dirY,
    input  logic       isWallBottom,
    input  logic       isWallTop,
    input  logic       isWallLeft,
    input  logic       isWallRight,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic [9:0] BulletS,
    output logic       bullet_active,
    output logic       fire_ready,
    output logic [2:0] bounce_count
);
    localparam int LW = (LIFETIME_FRAMES > 1) ? $clog2(LIFETIME_FRAMES + 1) : 1;
    localparam logic [LW-1:0] LIFE_INIT = LW'(LIFETIME_FRAMES);
    localparam logic [3:0]    MAX_B     = 4'(MAX_BOUNCES);
`ifdef BULLET_COOLDOWN_EN
    localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CW-1:0] CD_INIT = CW'(COOLDOWN_FRAMES);
`endif

    // state    | meaning
    // IDLE     | no bullet; a launch is accepted
    // FLYING   | bullet in flight, moves on each frame tick
    // EXPIRE   | one-cycle retirement
    // COOLDOWN | waiting out the relaunch delay
    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        EXPIRE
`ifdef BULLET_COOLDOWN_EN
        , COOLDOWN
`endif
    } state_t;

    state_t             state;
    logic               fc_q1, fc_q2, fc_q3, tick;
    logic signed [3:0]  vx, vy, vx_n, vy_n;
    logic [LW-1:0]      life;
    logic               bx, by, limit_hit;
    logic [3:0]         bounces_n;
    logic [2:0]         bounce_sat;
`ifdef BULLET_COOLDOWN_EN
    logic [CW-1:0]      cd;
`endif

    // Making a negative component positive: -8 has no 4-bit positive twin, so it becomes +7.
    function automatic logic signed [3:0] pos_mag(input logic signed [3:0] v);
        return (v == 4'sb1000) ? 4'sd7 : -v;
    endfunction

    assign tick    = fc_q2 & ~fc_q3;
    assign BulletS = 10'(BULLET_SIZE);

    always_comb begin
        vx_n = vx;
        if (isWallLeft && vx_n[3])
            vx_n = pos_mag(vx_n);
        if (isWallRight && !vx_n[3] && vx_n != 4'sd0)
            vx_n = -vx_n;
        vy_n = vy;
        if (isWallBottom && !vy_n[3] && vy_n != 4'sd0)
            vy_n = -vy_n;
        if (isWallTop && vy_n[3])
            vy_n = pos_mag(vy_n);
        bx         = vx_n[3] ^ vx[3];
        by         = vy_n[3] ^ vy[3];
        bounces_n  = {1'b0, bounce_count} + {3'b000, bx} + {3'b000, by};
        limit_hit  = bounces_n > MAX_B;
        bounce_sat = (bounces_n > 4'd7) ? 3'd7 : bounces_n[2:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            fc_q1         <= 1'b0;
            fc_q2         <= 1'b0;
            fc_q3         <= 1'b0;
            BulletX       <= '0;
            BulletY       <= '0;
            vx            <= '0;
            vy            <= '0;
            life          <= '0;
            bounce_count  <= '0;
            bullet_active <= 1'b0;
            fire_ready    <= 1'b1;
`ifdef BULLET_COOLDOWN_EN
            cd            <= '0;
`endif
        end else begin
            fc_q1 <= frame_clk;
            fc_q2 <= fc_q1;
            fc_q3 <= fc_q2;
            case (state)
                IDLE: begin
                    if (fire) begin
                        BulletX       <= tankX;
                        BulletY       <= tankY;
                        vx            <= dirX;
                        vy            <= dirY;
                        life          <= LIFE_INIT;
                        bounce_count  <= '0;
                        bullet_active <= 1'b1;
                        fire_ready    <= 1'b0;
                        state         <= FLYING;
                    end
                end
                FLYING: begin
                    if (tick) begin
                        if (limit_hit) begin
                            bullet_active <= 1'b0;
                            state         <= EXPIRE;
                        end else begin
                            vx           <= vx_n;
                            vy           <= vy_n;
                            BulletX      <= BulletX + {{6{vx_n[3]}}, vx_n};
                            BulletY      <= BulletY + {{6{vy_n[3]}}, vy_n};
                            bounce_count <= bounce_sat;
                            life         <= life - LW'(1);
                            if (life <= LW'(1)) begin
                                bullet_active <= 1'b0;
                                state         <= EXPIRE;
                            end
                        end
                    end
                end
                EXPIRE: begin
`ifdef BULLET_COOLDOWN_EN
                    cd    <= CD_INIT;
                    state <= COOLDOWN;
`else
                    fire_ready <= 1'b1;
                    state      <= IDLE;
`endif
                end
`ifdef BULLET_COOLDOWN_EN
                COOLDOWN: begin
                    if (cd == '0) begin
                        fire_ready <= 1'b1;
                        state      <= IDLE;
                    end else if (tick) begin
                        cd <= cd - CW'(1);
                        if (cd == CW'(1)) begin
                            fire_ready <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
`endif
                default: begin
                    bullet_active <= 1'b0;
                    fire_ready    <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bullet_motion.sv
// Bench for bullet_motion: spec-level model compared every cycle, plus hand-computed literal checkpoints.
module tb_bullet_motion;
    localparam int LIFE = 4;
    localparam int MAXB = 2;
    localparam int SIZE = 2;
`ifdef BULLET_COOLDOWN_EN
    localparam int CDF = 3;
`endif
    localparam int P_IDLE = 0, P_FLY = 1, P_EXP = 2, P_CD = 3;

    logic       Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0, fire = 1'b0;
    logic [9:0] tankX = '0, tankY = '0;
    logic [3:0] dirX = '0, dirY = '0;
    logic       isWallBottom = 1'b0, isWallTop = 1'b0, isWallLeft = 1'b0, isWallRight = 1'b0;
    logic [9:0] BulletX, BulletY, BulletS;
    logic       bullet_active, fire_ready;
    logic [2:0] bounce_count;

    int checks = 0;
    int errors = 0;

    bullet_motion #(
        .LIFETIME_FRAMES(LIFE),
        .MAX_BOUNCES(MAXB),
        .BULLET_SIZE(SIZE)
`ifdef BULLET_COOLDOWN_EN
        , .COOLDOWN_FRAMES(CDF)
`endif
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .fire(fire),
        .tankX(tankX),
        .tankY(tankY),
        .dirX(dirX),
        .dirY(dirY),
        .isWallBottom(isWallBottom),
        .isWallTop(isWallTop),
        .isWallLeft(isWallLeft),
        .isWallRight(isWallRight),
        .BulletX(BulletX),
        .BulletY(BulletY),
        .BulletS(BulletS),
        .bullet_active(bullet_active),
        .fire_ready(fire_ready),
        .bounce_count(bounce_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: integer position/velocity, phases named after the spec's states.
    int mx, my, mvx, mvy, mb, mlife, mcd, phase, nvx, nvy, nb;
    bit h0, h1, h2, mtick;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mx = 0; my = 0; mvx = 0; mvy = 0; mb = 0; mlife = 0; mcd = 0;
            phase = P_IDLE;
            h0 = 0; h1 = 0; h2 = 0;
        end else begin
            mtick = h1 && !h2;
            h2 = h1; h1 = h0; h0 = frame_clk;
            case (phase)
                P_IDLE: if (fire) begin
                    mx = tankX; my = tankY;
                    mvx = $signed(dirX); mvy = $signed(dirY);
                    mlife = LIFE; mb = 0; phase = P_FLY;
                end
                P_FLY: if (mtick) begin
                    nvx = mvx; nvy = mvy;
                    if (isWallLeft && nvx < 0) nvx = (nvx == -8) ? 7 : -nvx;
                    if (isWallRight && nvx > 0) nvx = -nvx;
                    if (isWallBottom && nvy > 0) nvy = -nvy;
                    if (isWallTop && nvy < 0) nvy = (nvy == -8) ? 7 : -nvy;
                    nb = mb + int'((nvx < 0) != (mvx < 0)) + int'((nvy < 0) != (mvy < 0));
                    if (nb > MAXB) phase = P_EXP;
                    else begin
                        mvx = nvx; mvy = nvy;
                        mx = (mx + nvx + 1024) % 1024;
                        my = (my + nvy + 1024) % 1024;
                        mb = (nb > 7) ? 7 : nb;
                        mlife = mlife - 1;
                        if (mlife == 0) phase = P_EXP;
                    end
                end
                P_EXP: begin
`ifdef BULLET_COOLDOWN_EN
                    phase = P_CD; mcd = CDF;
`else
                    phase = P_IDLE;
`endif
                end
                P_CD: begin
                    if (mcd == 0) phase = P_IDLE;
                    else if (mtick) begin
                        mcd = mcd - 1;
                        if (mcd == 0) phase = P_IDLE;
                    end
                end
                default: phase = P_IDLE;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("model_x", BulletX, mx);
            chk("model_y", BulletY, my);
            chk("model_size", BulletS, SIZE);
            chk("model_active", bullet_active, int'(phase == P_FLY));
            chk("model_ready", fire_ready, int'(phase == P_IDLE));
            chk("model_bounces", bounce_count, mb);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1; cyc(4);
        frame_clk = 1'b0; cyc(4);
    endtask

    task automatic ticks(input int n);
        repeat (n) frame_tick();
    endtask

    task automatic launch(input int x, input int y, input int dx, input int dy);
        tankX = 10'(x); tankY = 10'(y); dirX = 4'(dx); dirY = 4'(dy);
        fire = 1'b1; cyc(1); fire = 1'b0;
    endtask

    task automatic walls(input bit b, input bit t, input bit l, input bit r);
        isWallBottom = b; isWallTop = t; isWallLeft = l; isWallRight = r;
    endtask

    task automatic settle();
`ifdef BULLET_COOLDOWN_EN
        ticks(CDF);
`endif
        cyc(1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, BulletX, 0);
        chk({tag, "_y"}, BulletY, 0);
        chk({tag, "_active"}, bullet_active, 0);
        chk({tag, "_ready"}, fire_ready, 1);
        chk({tag, "_bounces"}, bounce_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 Reset = 1'b1;
        #1 chk_reset_vals("por");
        chk("por_size", BulletS, 2);
        cyc(2);
        Reset = 1'b0;
        cyc(2);

        // Launch, straight flight, ignored fire, lifetime expiry after exactly 4 ticks
        launch(320, 240, 3, -2);
        chk("launch_x", BulletX, 320);
        chk("launch_y", BulletY, 240);
        chk("launch_active", bullet_active, 1);
        chk("launch_ready", fire_ready, 0);
        frame_tick();
        chk("tick1_x", BulletX, 323);
        chk("tick1_y", BulletY, 238);
        frame_tick();
        chk("tick2_x", BulletX, 326);
        chk("tick2_y", BulletY, 236);
        launch(10, 10, 1, 1);
        chk("ignored_fire_x", BulletX, 326);
        chk("ignored_fire_active", bullet_active, 1);
        frame_tick();
        chk("tick3_active", bullet_active, 1);
        frame_tick();
        chk("life_end_active", bullet_active, 0);
        chk("life_end_x", BulletX, 332);
        chk("life_end_y", BulletY, 232);
        settle();
        chk("after_expire_ready", fire_ready, 1);

        // Right-wall bounce, held flag gives no second bounce
        launch(600, 200, 3, 1);
        chk("relaunch_x", BulletX, 600);
        walls(0, 0, 0, 1);
        frame_tick();
        chk("bounce_x", BulletX, 597);
        chk("bounce_y", BulletY, 201);
        chk("bounce_cnt", bounce_count, 1);
        frame_tick();
        chk("held_x", BulletX, 594);
        chk("held_y", BulletY, 202);
        chk("held_cnt", bounce_count, 1);
        walls(0, 0, 0, 0);
        ticks(2);
        chk("bounce_run_end", bullet_active, 0);
        settle();

        // Bounce limit: third alternating hit retires without moving
        launch(100, 100, 2, 0);
        walls(0, 0, 0, 1); frame_tick();
        chk("lim1_x", BulletX, 98);
        walls(0, 0, 1, 0); frame_tick();
        chk("lim2_x", BulletX, 100);
        chk("lim2_cnt", bounce_count, 2);
        walls(0, 0, 0, 1); frame_tick();
        walls(0, 0, 0, 0);
        chk("lim3_active", bullet_active, 0);
        chk("lim3_cnt", bounce_count, 2);
        chk("lim3_x", BulletX, 100);
        chk("lim3_y", BulletY, 100);
        settle();

        // -8 reflects to +7
        launch(50, 50, -8, 0);
        walls(0, 0, 1, 0); frame_tick(); walls(0, 0, 0, 0);
        chk("neg8_x", BulletX, 57);
        chk("neg8_cnt", bounce_count, 1);
        ticks(3);
        settle();

        // Zero velocity with every flag raised: no bounce, no motion
        launch(200, 300, 0, 0);
        walls(1, 1, 1, 1); frame_tick(); walls(0, 0, 0, 0);
        chk("zero_x", BulletX, 200);
        chk("zero_y", BulletY, 300);
        chk("zero_cnt", bounce_count, 0);
        ticks(3);
        chk("zero_end_active", bullet_active, 0);
        settle();

        // Wrap modulo 1024 on both axes
        launch(1022, 5, 3, -7);
        frame_tick();
        chk("wrap_x", BulletX, 1);
        chk("wrap_y", BulletY, 1022);
        ticks(3);
        settle();

`ifdef BULLET_COOLDOWN_EN
        launch(10, 10, 1, 1);
        ticks(LIFE);
        chk("cd_ready0", fire_ready, 0);
        launch(20, 20, 1, 1);
        chk("cd_fire_ignored", bullet_active, 0);
        ticks(CDF - 1);
        chk("cd_ready_mid", fire_ready, 0);
        frame_tick();
        chk("cd_ready1", fire_ready, 1);
`endif

        // Asynchronous reset mid-flight
        launch(400, 100, 1, 1);
        chk("pre_reset_x", BulletX, 400);
        chk("pre_reset_y", BulletY, 100);
        #2 Reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        cyc(1);
        Reset = 1'b0;
        cyc(3);
        chk("post_reset_ready", fire_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
